scan_display_mux: RTL and testbench

- Parametrised time-multiplexed 7-segment display driver; next generation of the fixed 4-digit scanner.
- Drives NDIG digits with hex decoding, a decimal point per digit, and a per-digit enable.
- Adds leading-zero blanking, an inter-digit blanking gap (anti-ghosting), 16-level brightness PWM, frame-coherent input capture and a frame tick.
- Sits between display-value producers and the board segment/anode pins.

---
 rtl/scan_display_mux.sv | 145 ++++++++++++++
 tb/tb_scan_display_mux.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/scan_display_mux.sv
// rtl/scan_display_mux.sv - time-multiplexed hex 7-segment scanner with blanking, PWM and frame capture
module scan_display_mux #(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [4*NDIG-1:0]   digits,
    input  logic [NDIG-1:0]     dp,
    input  logic [NDIG-1:0]     digit_en,
    input  logic                lzb,
    input  logic [3:0]          bright,
    output logic [6:0]          seg,
    output logic                dp_n,
    output logic [NDIG-1:0]     an,
    output logic                frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYC);
    localparam logic [SW-1:0] SEL_MAX = SW'(NDIG - 1);

    logic [CW-1:0]      r_cnt;
    logic [SW-1:0]      r_sel;
    logic [3:0]         r_pwm;
    logic [4*NDIG-1:0]  r_sh_digits;
    logic [NDIG-1:0]    r_sh_dp;
    logic [NDIG-1:0]    r_sh_en;
    logic               r_sh_lzb;
    logic [3:0]         r_sh_bright;
    logic [6:0]         r_seg;
    logic               r_dp_n;
    logic [NDIG-1:0]    r_an;
    logic               r_frame_tick;

    logic               w_load;
    logic               w_cnt_wrap;
    logic               w_sel_wrap;
    logic [4*NDIG-1:0]  w_digits;
    logic [NDIG-1:0]    w_dp;
    logic [NDIG-1:0]    w_en;
    logic               w_lzb;
    logic [3:0]         w_bright;
    logic [NDIG-1:0]    w_blank;
    logic               w_zero;
    logic [3:0]         w_dig;
    logic               w_lit;
    logic [NDIG-1:0]    w_an_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign w_load     = (r_sel == '0) && (r_cnt == '0);
    assign w_cnt_wrap = (r_cnt == CNT_MAX);
    assign w_sel_wrap = (r_sel == SEL_MAX);

    // On the capture cycle the fresh inputs are used directly so the new frame starts coherent.
    assign w_digits = w_load ? digits   : r_sh_digits;
    assign w_dp     = w_load ? dp       : r_sh_dp;
    assign w_en     = w_load ? digit_en : r_sh_en;
    assign w_lzb    = w_load ? lzb      : r_sh_lzb;
    assign w_bright = w_load ? bright   : r_sh_bright;

    always_comb begin
        w_blank = '0;
        w_zero  = w_lzb;
        for (int i = NDIG - 1; i >= 1; i--) begin
            w_zero     = w_zero && (w_digits[4*i +: 4] == 4'h0);
            w_blank[i] = w_zero;
        end
    end

    assign w_dig = w_digits[4*r_sel +: 4];
    assign w_lit = (r_cnt >= BLANK) && w_en[r_sel] && (r_pwm <= w_bright) && !w_blank[r_sel];

    always_comb begin
        w_an_next = '1;
        if (w_lit) begin
            w_an_next[r_sel] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_sel        <= '0;
            r_pwm        <= 4'd0;
            r_sh_digits  <= '0;
            r_sh_dp      <= '0;
            r_sh_en      <= '0;
            r_sh_lzb     <= 1'b0;
            r_sh_bright  <= 4'd0;
            r_seg        <= 7'h7F;
            r_dp_n       <= 1'b1;
            r_an         <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
            if (w_cnt_wrap) begin
                r_cnt <= '0;
                r_sel <= w_sel_wrap ? '0 : r_sel + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load) begin
                r_sh_digits <= digits;
                r_sh_dp     <= dp;
                r_sh_en     <= digit_en;
                r_sh_lzb    <= lzb;
                r_sh_bright <= bright;
            end
            r_seg        <= w_lit ? hex_to_seg(w_dig) : 7'h7F;
            r_dp_n       <= w_lit ? ~w_dp[r_sel] : 1'b1;
            r_an         <= w_an_next;
            r_frame_tick <= w_cnt_wrap && w_sel_wrap;
        end
    end

    assign seg        = r_seg;
    assign dp_n       = r_dp_n;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_scan_display_mux.sv
// tb/tb_scan_display_mux.sv - directed vector bench for scan_display_mux (NDIG=4, SCAN_DIV=8, BLANK_CYC=2)
module tb_scan_display_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lzb;
    logic [3:0]  bright;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_tick;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scan_display_mux #(
        .NDIG      (4),
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .digits     (digits),
        .dp         (dp),
        .digit_en   (digit_en),
        .lzb        (lzb),
        .bright     (bright),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_tick (frame_tick)
    );

    // exp_seg packs {d3,d2,d1,d0}; exp_lit marks digits that light (enabled and not blanked)
    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lzb;
        logic [3:0]  bright;
        logic [3:0]  exp_lit;
        logic [27:0] exp_seg;
        logic [3:0]  exp_dpn;
    } vec_t;

    vec_t vecs[10];
    vec_t c1;
    vec_t c2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {an,seg,dp_n,tick}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        digits   = v.digits;
        dp       = v.dp;
        digit_en = v.en;
        lzb      = v.lzb;
        bright   = v.bright;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        repeat (3) tick();
        cmp("reset_state", {an, seg, dp_n, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
    endtask

    // k counts edges since reset release; state before edge k is cnt=k%8, sel=(k/8)%4, pwm=k%16
    task automatic check_cycle(input string tag, input int k, input vec_t v);
        int sel;
        int cnt;
        int pwm;
        logic lit;
        logic ft;
        logic [12:0] e;
        sel = (k / 8) % 4;
        cnt = k % 8;
        pwm = k % 16;
        ft  = (k % 32 == 31);
        lit = (cnt >= 2) && v.exp_lit[sel] && (pwm <= int'(v.bright));
        e = {4'hF, 7'h7F, 1'b1, ft};
        if (lit) e = {~(4'b0001 << sel), v.exp_seg[7*sel +: 7], v.exp_dpn[sel], ft};
        cmp($sformatf("%s k=%0d", tag, k), {an, seg, dp_n, frame_tick}, e);
    endtask

    initial begin
        reset    = 1'b0;
        digits   = 16'h1234;
        dp       = 4'h0;
        digit_en = 4'hF;
        lzb      = 1'b0;
        bright   = 4'hF;

        vecs[0] = '{16'h1234, 4'b0000, 4'b1111, 1'b0, 4'hF, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h0070, 4'b0000, 4'b1111, 1'b1, 4'hF, 4'b0011, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0070, 4'b0000, 4'b1111, 1'b0, 4'hF, 4'b1111, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111};
        vecs[3] = '{16'h1234, 4'b0000, 4'b0001, 1'b0, 4'h3, 4'b0001, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[4] = '{16'h1234, 4'b0101, 4'b1011, 1'b0, 4'hF, 4'b1011, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1010};
        vecs[5] = '{16'h0070, 4'b1111, 4'b1111, 1'b1, 4'hF, 4'b0011, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1100};
        vecs[6] = '{16'h89AB, 4'b1010, 4'b1111, 1'b1, 4'hF, 4'b1111, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b0101};
        vecs[7] = '{16'hCDEF, 4'b0000, 4'b1111, 1'b0, 4'h7, 4'b1111, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b1111};
        vecs[8] = '{16'h5600, 4'b0000, 4'b1111, 1'b1, 4'hF, 4'b1111, {7'h12, 7'h02, 7'h40, 7'h40}, 4'b1111};
        vecs[9] = '{16'h0000, 4'b0001, 4'b1111, 1'b1, 4'hF, 4'b0001, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1110};

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i]);
            do_reset();
            reset = 1'b1;
            for (int k = 0; k < 64; k++) begin
                tick();
                check_cycle($sformatf("vec%0d", i), k, vecs[i]);
            end
        end

        // Input change mid-frame (during digit-2 slot) only takes effect at the next frame
        c1 = '{16'h1111, 4'b0000, 4'b1111, 1'b0, 4'hF, 4'b1111, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b1111};
        c2 = '{16'h2222, 4'b0000, 4'b1111, 1'b0, 4'hF, 4'b1111, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111};
        apply(c1);
        do_reset();
        reset = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick();
            check_cycle("coherence", k, (k < 32) ? c1 : c2);
            if (k == 18) digits = 16'h2222;
        end

        // Reset sampled at sel=2, cnt=5, then restart from digit 0
        apply(vecs[0]);
        do_reset();
        reset = 1'b1;
        for (int k = 0; k < 21; k++) begin
            tick();
            check_cycle("pre_midreset", k, vecs[0]);
        end
        reset = 1'b0;
        tick();
        cmp("midreset_state", {an, seg, dp_n, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            check_cycle("post_midreset", k, vecs[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
